// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier controller.
package booth_pkg;

  localparam int WIDTH  = 16;
  localparam int ITER   = WIDTH / 2;
  localparam int PROD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic neg;
    logic zero;
    logic one;
    logic two;
  } booth_ctl_t;

  // Radix-4 Booth digit for one overlapping multiplier triplet; neg only for non-zero digits.
  function automatic booth_ctl_t booth_enc(input logic [2:0] trip);
    booth_ctl_t c;
    c = '0;
    unique case (trip)
      3'b000, 3'b111: c.zero = 1'b1;
      3'b001, 3'b010: c.one  = 1'b1;
      3'b011:         c.two  = 1'b1;
      3'b100: begin
        c.two = 1'b1;
        c.neg = 1'b1;
      end
      3'b101, 3'b110: begin
        c.one = 1'b1;
        c.neg = 1'b1;
      end
      default:        c.zero = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/booth_seq_mul_ctrl_if.sv
// Operand and product handshake channels of the sequential Booth multiplier.
interface booth_seq_mul_ctrl_if;
  import booth_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] out_prod;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod
  );

endinterface

// File: rtl/booth_seq_mul_ctrl_gen_prod.sv
// Booth partial-product generator: selects 0, +-A or +-2A, sign-extended to the full product width.
module gen_prod
  import booth_pkg::*;
(
  input  logic [WIDTH-1:0]  a,
  input  booth_ctl_t        ctl,
  output logic [PROD_W-1:0] pp
);

  logic [PROD_W-1:0] mag;

  // Sign-extend before doubling so -32768 * 2 stays representable.
  always_comb begin
    mag = '0;
    if (ctl.zero) begin
      mag = '0;
    end else if (ctl.one) begin
      mag = {{(PROD_W-WIDTH){a[WIDTH-1]}}, a};
    end else if (ctl.two) begin
      mag = {{(PROD_W-WIDTH-1){a[WIDTH-1]}}, a, 1'b0};
    end
    pp = ctl.neg ? (~mag + 1'b1) : mag;
  end

endmodule

// File: rtl/booth_seq_mul_ctrl.sv
// Iterative radix-4 Booth multiplier controller: one signed 16x16 multiply, two multiplier bits per cycle.
module booth_seq_mul_ctrl #(
  parameter int WIDTH      = 16,
  parameter int EARLY_DONE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  booth_seq_mul_ctrl_if.slave   bus,
  output logic                  busy
);
  import booth_pkg::*;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH:0]    b_ext_q, b_ext_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [2:0]        cnt_q, cnt_d;

  logic [2:0]        trip;
  booth_ctl_t        ctl;
  logic [PROD_W-1:0] pp;
  logic [PROD_W-1:0] acc_sum;
  logic [4:0]        rest_lsb;
  logic [WIDTH:0]    rest_mask;
  logic [WIDTH:0]    rest_diff;
  logic              rest_uniform;
  logic              last_iter;

  gen_prod u_gen_prod (
    .a   (a_q),
    .ctl (ctl),
    .pp  (pp)
  );

  // Remaining triplets all encode zero once every multiplier bit above this one matches the sign.
  always_comb begin
    trip         = b_ext_q[{cnt_q, 1'b0} +: 3];
    ctl          = booth_enc(trip);
    acc_sum      = acc_q + (pp << {cnt_q, 1'b0});
    rest_lsb     = {1'b0, cnt_q, 1'b0} + 5'd2;
    rest_mask    = {(WIDTH+1){1'b1}} << rest_lsb;
    rest_diff    = b_ext_q ^ {(WIDTH+1){b_ext_q[WIDTH]}};
    rest_uniform = ((rest_diff & rest_mask) == '0);
    last_iter    = (cnt_q == 3'(ITER-1)) || ((EARLY_DONE != 0) && rest_uniform);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_ext_d = b_ext_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          a_d     = bus.in_a;
          b_ext_d = {bus.in_b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 3'd1;
        if (last_iter) begin
          state_d = DONE;
          prod_d  = acc_sum;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_ext_q <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_ext_q <= b_ext_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_prod  = prod_q;
  assign busy          = (state_q == RUN);

endmodule
